// File: rtl/diff_pkg.sv
// Shared constants, sample type and signed-overflow helper for the diff_comb differencer.
package diff_pkg;

   localparam int DATA_W_DEFAULT = 32;
   localparam int DELAY_MAX      = 8;

   typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

   // a - b overflowed when operand signs differ and the result sign left the minuend's
   function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
      return (a_s != b_s) && (r_s != a_s);
   endfunction

endpackage

// File: rtl/diff_delay_line.sv
// DEPTH-deep shift register of DATA_W words with shift enable and synchronous clear.
module diff_delay_line #(
   parameter int W     = 32,
   parameter int DEPTH = 3
) (
   input  logic         clk,
   input  logic         areset_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [DEPTH-1:0][W-1:0] tap_q;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         tap_q <= '0;
      end else if (clr_i) begin
         tap_q <= '0;
      end else if (en_i) begin
         tap_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
      end
   end

   assign q_o = tap_q[DEPTH-1];

endmodule

// File: rtl/diff_comb.sv
// Two-stage streaming differencer: first difference, then comb against d1 delayed by DELAY.
// Optional sticky signed-overflow flag when DIFF_OVF_EN is defined.
module diff_comb
   import diff_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DELAY  = 3
) (
   input  logic              clk,
   input  logic              areset_n,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef DIFF_OVF_EN
   ,
   output logic              ovf_sticky
`endif
);

   // out-of-range DELAY values are clamped into 1..DELAY_MAX
   localparam int DEPTH = (DELAY > DELAY_MAX) ? DELAY_MAX : ((DELAY < 1) ? 1 : DELAY);

   logic [DATA_W-1:0] x_prev_q, d1_q, d1_d, hist_q, y_d, out_data_q;
   logic              s1_valid_q, out_valid_q;
   logic              advance, accept, shift;

   assign advance = !(out_valid_q && !out_ready);
   assign accept  = in_valid && advance && !clr;
   assign shift   = advance && s1_valid_q;
   assign d1_d    = in_data - x_prev_q;
   assign y_d     = d1_q - hist_q;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         x_prev_q    <= '0;
         d1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (clr) begin
         x_prev_q    <= '0;
         d1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= accept;
         out_valid_q <= s1_valid_q;
         if (accept) begin
            x_prev_q <= in_data;
            d1_q     <= d1_d;
         end
         if (s1_valid_q) out_data_q <= y_d;
      end
   end

   diff_delay_line #(.W(DATA_W), .DEPTH(DEPTH)) u_hist (
      .clk      (clk),
      .areset_n (areset_n),
      .clr_i    (clr),
      .en_i     (shift),
      .d_i      (d1_q),
      .q_o      (hist_q)
   );

   assign in_ready  = advance;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

`ifdef DIFF_OVF_EN
   logic ovf_q, ovf1, ovf2;

   assign ovf1 = accept && sub_ovf(in_data[DATA_W-1], x_prev_q[DATA_W-1], d1_d[DATA_W-1]);
   assign ovf2 = shift && !clr && sub_ovf(d1_q[DATA_W-1], hist_q[DATA_W-1], y_d[DATA_W-1]);

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n)  ovf_q <= 1'b0;
      else if (clr)   ovf_q <= 1'b0;
      else            ovf_q <= ovf_q | ovf1 | ovf2;
   end

   assign ovf_sticky = ovf_q;
`endif

endmodule
